// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, op codes, port ids.
package mem_arb_pkg;

    localparam int unsigned NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arbState_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the port that was not granted last wins a tie.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 lastGnt,
    output logic [NUM_PORTS-1:0] gnt_c
);

    always_comb begin
        gnt_c = '0;
        if (req0 && req1) begin
            gnt_c = (lastGnt == PORT0) ? 2'b10 : 2'b01;
        end else if (req0) begin
            gnt_c = 2'b01;
        end else if (req1) begin
            gnt_c = 2'b10;
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter serialising two requesters onto the single-port Memory
// interface; one transaction in flight, acknowledged with a one-cycle pulse.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AddrSize = 8,
    parameter int unsigned DataSize = 32
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Req0,
    input  logic                RW0,
    input  logic [AddrSize-1:0] Addr0,
    input  logic [DataSize-1:0] WData0,
    output logic                Ack0,
    output logic [DataSize-1:0] RData0,
    input  logic                Req1,
    input  logic                RW1,
    input  logic [AddrSize-1:0] Addr1,
    input  logic [DataSize-1:0] WData1,
    output logic                Ack1,
    output logic [DataSize-1:0] RData1,
    output logic                MemValid,
    output logic                MemR_W,
    output logic [AddrSize-1:0] MemAddr,
    output logic [DataSize-1:0] MemDin,
    input  logic [DataSize-1:0] MemDout,
    output logic                Busy
);

    arbState_t state, stateNxt;

    logic                 lastGnt, lastGntNxt;
    logic                 curPort, curPortNxt;
    logic [NUM_PORTS-1:0] gnt;

    logic                memValidNxt, memRWNxt, ack0Nxt, ack1Nxt, busyNxt;
    logic [AddrSize-1:0] memAddrNxt;
    logic [DataSize-1:0] memDinNxt, rData0Nxt, rData1Nxt;

    rr_arb2 uArb (
        .req0   (Req0),
        .req1   (Req1),
        .lastGnt(lastGnt),
        .gnt_c  (gnt)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // The Mem* output registers double as the latched request fields.
    always_comb begin
        stateNxt    = state;
        lastGntNxt  = lastGnt;
        curPortNxt  = curPort;
        memValidNxt = 1'b0;
        memRWNxt    = MemR_W;
        memAddrNxt  = MemAddr;
        memDinNxt   = MemDin;
        ack0Nxt     = 1'b0;
        ack1Nxt     = 1'b0;
        rData0Nxt   = RData0;
        rData1Nxt   = RData1;

        case (state)
            IDLE: begin
                if (gnt != 2'b00) begin
                    curPortNxt  = gnt[1];
                    lastGntNxt  = gnt[1];
                    memValidNxt = 1'b1;
                    stateNxt    = ISSUE;
                    if (gnt[1]) begin
                        memRWNxt   = RW1;
                        memAddrNxt = Addr1;
                        memDinNxt  = WData1;
                    end else begin
                        memRWNxt   = RW0;
                        memAddrNxt = Addr0;
                        memDinNxt  = WData0;
                    end
                end
            end
            ISSUE: begin
                if (MemR_W == RW_WRITE) begin
                    stateNxt = DONE;
                    ack0Nxt  = (curPort == PORT0);
                    ack1Nxt  = (curPort == PORT1);
                end else begin
                    stateNxt = WAIT;
                end
            end
            WAIT: begin
                stateNxt = DONE;
                ack0Nxt  = (curPort == PORT0);
                ack1Nxt  = (curPort == PORT1);
                if (curPort == PORT1) begin
                    rData1Nxt = MemDout;
                end else begin
                    rData0Nxt = MemDout;
                end
            end
            DONE: begin
                stateNxt = IDLE;
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase

        busyNxt = (stateNxt != IDLE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            lastGnt  <= PORT1;
            curPort  <= PORT0;
            MemValid <= 1'b0;
            MemR_W   <= 1'b0;
            MemAddr  <= '0;
            MemDin   <= '0;
            Ack0     <= 1'b0;
            Ack1     <= 1'b0;
            RData0   <= '0;
            RData1   <= '0;
            Busy     <= 1'b0;
        end else begin
            lastGnt  <= lastGntNxt;
            curPort  <= curPortNxt;
            MemValid <= memValidNxt;
            MemR_W   <= memRWNxt;
            MemAddr  <= memAddrNxt;
            MemDin   <= memDinNxt;
            Ack0     <= ack0Nxt;
            Ack1     <= ack1Nxt;
            RData0   <= rData0Nxt;
            RData1   <= rData1Nxt;
            Busy     <= busyNxt;
        end
    end

endmodule
